// File: rtl/conv_row_stationary_core.sv
// 7x7 ifmap by 3x3 filter valid convolution, row-stationary style.
// Operands stream in from an internal ROM over a fixed 72-slot schedule;
// filter row u is then swept across all five output rows, one row per cycle.
module conv_row_stationary_core #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 6,
  parameter int unsigned SLOTS = 72
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic          read,
  output logic [DW-1:0] DATA_OUT [0:4][0:4]
);

  localparam int unsigned SW = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [1:0]    d_q, d_d;

  logic [DW-1:0] img_q  [0:6][0:6];
  logic [DW-1:0] img_d  [0:6][0:6];
  logic [DW-1:0] w_q    [0:2][0:2];
  logic [DW-1:0] w_d    [0:2][0:2];
  logic [DW-1:0] psum_q [0:4][0:4];
  logic [DW-1:0] psum_d [0:4][0:4];
  logic [DW-1:0] dout_q [0:4][0:4];
  logic [DW-1:0] dout_d [0:4][0:4];
  logic [DW-1:0] pe_c   [0:4][0:4];

  logic          arm_c, load_c, acc_c, wr_c;
  logic [DW-1:0] rom_c, sample_c;
  logic          slot_img_c, slot_w_c;
  logic [2:0]    irow_c, icol_c;
  logic [1:0]    wrow_c, wcol_c;
  logic [SW-1:0] off_c;
  logic [1:0]    u_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: en always wins and re-arms
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED:   state_d = RUN;
        RUN:     if (s_q == SW'(SLOTS - 1)) state_d = DRAIN;
        DRAIN:   if (d_q == 2'd3) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Control strobes decoded from the current state
  always_comb begin
    arm_c  = en;
    load_c = (state_q == RUN) && !en;
    acc_c  = (state_q == DRAIN) && (d_q != 2'd3) && !en;
    wr_c   = (state_q == DRAIN) && (d_q == 2'd3) && !en;
  end

  // Operand ROM: pixels 0..48, unit weights 49..57, zero above
  always_comb begin
    rom_c = '0;
    if (addr < AW'(49))      rom_c = DW'(addr);
    else if (addr < AW'(58)) rom_c = DW'(1);
    sample_c = read ? rom_c : '0;
  end

  // Slot decode: which register (if any) the current sample lands in
  always_comb begin
    slot_img_c = 1'b0;
    slot_w_c   = 1'b0;
    irow_c     = '0;
    icol_c     = '0;
    wrow_c     = '0;
    wcol_c     = '0;
    off_c      = '0;
    if (s_q < SW'(7)) begin
      slot_img_c = 1'b1; irow_c = 3'd2; off_c = s_q;
    end else if (s_q < SW'(12)) begin
      wrow_c = 2'd2; off_c = s_q - SW'(7);
    end else if (s_q < SW'(19)) begin
      slot_img_c = 1'b1; irow_c = 3'd1; off_c = s_q - SW'(12);
    end else if (s_q < SW'(24)) begin
      wrow_c = 2'd1; off_c = s_q - SW'(19);
    end else if (s_q < SW'(31)) begin
      slot_img_c = 1'b1; irow_c = 3'd0; off_c = s_q - SW'(24);
    end else if (s_q < SW'(36)) begin
      wrow_c = 2'd0; off_c = s_q - SW'(31);
    end else if (s_q < SW'(45)) begin
      irow_c = 3'd3; off_c = s_q - SW'(36);
    end else if (s_q < SW'(54)) begin
      irow_c = 3'd4; off_c = s_q - SW'(45);
    end else if (s_q < SW'(63)) begin
      irow_c = 3'd5; off_c = s_q - SW'(54);
    end else begin
      irow_c = 3'd6; off_c = s_q - SW'(63);
    end
    // Weight slots are the 5-wide groups below 36; image rows 3..6 are 9-wide
    if (s_q >= SW'(36)) slot_img_c = (off_c < SW'(7));
    else if (!slot_img_c) slot_w_c = (off_c < SW'(3));
    icol_c = off_c[2:0];
    wcol_c = off_c[1:0];
  end

  // PE(u,r) row partial sums for the filter row selected by the drain counter
  always_comb begin
    u_c = (d_q == 2'd3) ? 2'd0 : d_q;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        pe_c[r][c] = '0;
        for (int v = 0; v < 3; v++) begin
          pe_c[r][c] = pe_c[r][c] + w_q[u_c][v] * img_q[3'(r) + 3'(u_c)][3'(c + v)];
        end
      end
    end
  end

  // Datapath next values: counters, operand capture, vertical accumulation, output
  always_comb begin
    s_d    = s_q;
    d_d    = d_q;
    img_d  = img_q;
    w_d    = w_q;
    psum_d = psum_q;
    dout_d = dout_q;
    if (arm_c) begin
      s_d = '0;
      d_d = '0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          psum_d[r][c] = '0;
    end
    if (load_c) begin
      s_d = (s_q == SW'(SLOTS - 1)) ? '0 : s_q + SW'(1);
      if (slot_img_c) img_d[irow_c][icol_c] = sample_c;
      if (slot_w_c)   w_d[wrow_c][wcol_c]   = sample_c;
    end
    if (acc_c) begin
      d_d = d_q + 2'd1;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          psum_d[r][c] = psum_q[r][c] + pe_c[r][c];
    end
    if (wr_c) begin
      d_d    = '0;
      dout_d = psum_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= '0;
      d_q    <= '0;
      img_q  <= '{default: '0};
      w_q    <= '{default: '0};
      psum_q <= '{default: '0};
      dout_q <= '{default: '0};
    end else begin
      s_q    <= s_d;
      d_q    <= d_d;
      img_q  <= img_d;
      w_q    <= w_d;
      psum_q <= psum_d;
      dout_q <= dout_d;
    end
  end

  assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_conv_row_stationary_core.sv
// Directed bench for conv_row_stationary_core with hand-derived expected maps.
module tb_conv_row_stationary_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  addr;
  logic        rd;
  logic [15:0] data_out [0:4][0:4];

  int n_cmp = 0;
  int n_err = 0;

  conv_row_stationary_core dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .addr     (addr),
    .read     (rd),
    .DATA_OUT (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All weights are 1: 3x3 window sum of 7i+j centred on (r+1,c+1)
  function automatic int exp_std(input int r, input int c);
    return 9 * (7 * (r + 1) + c + 1);
  endfunction

  // Filter row 0 zeroed: only ifmap rows r+1 and r+2 contribute
  function automatic int exp_f0(input int r, input int c);
    return 42 * r + 6 * c + 69;
  endfunction

  function automatic logic [5:0] slot_addr(input int s);
    int base  [10] = '{14, 55, 7, 52, 0, 49, 21, 28, 35, 42};
    int start [10] = '{0, 7, 12, 19, 24, 31, 36, 45, 54, 63};
    int g = 0;
    for (int k = 0; k < 10; k++) if (s >= start[k]) g = k;
    return 6'(base[g] + s - start[g]);
  endfunction

  // en high across 'hold' rising edges; the next edge moves ARMED -> RUN
  task automatic arm(input int hold);
    @(negedge clk);
    en = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    en = 1'b0;
  endtask

  // One slot per rising edge; read forced low for slots zlo..zhi
  task automatic drive_slots(input int from, input int to, input int zlo, input int zhi);
    for (int s = from; s <= to; s++) begin
      @(negedge clk);
      addr = slot_addr(s);
      rd   = !(s >= zlo && s <= zhi);
    end
    @(negedge clk);
    addr = '0;
    rd   = 1'b0;
  endtask

  task automatic run_full(input int hold, input int zlo, input int zhi);
    arm(hold);
    drive_slots(0, 71, zlo, zhi);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; rd = 1'b0; addr = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'd0) begin
          n_err++;
          $display("FAIL reset[%0d][%0d]: got %0d want 0", r, c, data_out[r][c]);
        end
      end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_standard;
    logic [15:0] lit;
    arm(1);
    drive_slots(0, 71, -1, -1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'd0) begin
          n_err++;
          $display("FAIL std_early[%0d][%0d]: got %0d want 0", r, c, data_out[r][c]);
        end
      end
    repeat (8) @(negedge clk);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'(exp_std(r, c))) begin
          n_err++;
          $display("FAIL std[%0d][%0d]: got %0d want %0d", r, c, data_out[r][c], exp_std(r, c));
        end
      end
    lit = 16'd72;
    n_cmp++;
    if (data_out[0][0] !== lit) begin
      n_err++;
      $display("FAIL std_corner00: got %0d want %0d", data_out[0][0], lit);
    end
    lit = 16'd360;
    n_cmp++;
    if (data_out[4][4] !== lit) begin
      n_err++;
      $display("FAIL std_corner44: got %0d want %0d", data_out[4][4], lit);
    end
  endtask

  task automatic test_read_zero;
    run_full(1, 0, 71);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'd0) begin
          n_err++;
          $display("FAIL rdzero[%0d][%0d]: got %0d want 0", r, c, data_out[r][c]);
        end
      end
  endtask

  task automatic test_filter_row0_zero;
    run_full(1, -1, -1);
    run_full(1, 31, 35);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'(exp_f0(r, c))) begin
          n_err++;
          $display("FAIL f0zero[%0d][%0d]: got %0d want %0d", r, c, data_out[r][c], exp_f0(r, c));
        end
      end
  endtask

  task automatic test_abort;
    arm(1);
    drive_slots(0, 39, -1, -1);
    arm(1);
    repeat (10) @(negedge clk);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'(exp_f0(r, c))) begin
          n_err++;
          $display("FAIL abort_hold[%0d][%0d]: got %0d want %0d", r, c, data_out[r][c], exp_f0(r, c));
        end
      end
    run_full(1, -1, -1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'(exp_std(r, c))) begin
          n_err++;
          $display("FAIL abort_rerun[%0d][%0d]: got %0d want %0d", r, c, data_out[r][c], exp_std(r, c));
        end
      end
  endtask

  task automatic test_rst_mid_run;
    arm(1);
    drive_slots(0, 49, -1, -1);
    rst = 1'b0;
    #1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'd0) begin
          n_err++;
          $display("FAIL rst_mid[%0d][%0d]: got %0d want 0", r, c, data_out[r][c]);
        end
      end
    @(negedge clk);
    rst = 1'b1;
    run_full(1, -1, -1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'(exp_std(r, c))) begin
          n_err++;
          $display("FAIL rst_rerun[%0d][%0d]: got %0d want %0d", r, c, data_out[r][c], exp_std(r, c));
        end
      end
  endtask

  task automatic test_en_held;
    run_full(1, 0, 71);
    run_full(3, -1, -1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if (data_out[r][c] !== 16'(exp_std(r, c))) begin
          n_err++;
          $display("FAIL en_held[%0d][%0d]: got %0d want %0d", r, c, data_out[r][c], exp_std(r, c));
        end
      end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_read_zero();
    test_filter_row0_zero();
    test_abort();
    test_rst_mid_run();
    test_en_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
